// File: rtl/sfx_sequencer.sv
// sfx_sequencer: plays fixed 4-note square-wave sound effects on trigger pulses
// Ports:
//   clk        in   system clock
//   reset_n    in   async active-low reset
//   frame_end  in   one-cycle pulse at end of each video frame
//   eat_sound  in   trigger, priority 1 (lowest)
//   hit_sound  in   trigger, priority 2
//   die_sound  in   trigger, priority 3 (highest)
//   audio_out  out  square wave, 0 when idle
//   volume     out  4-bit amplitude, 0 when idle
//   busy       out  1 while an effect plays
//   sfx_id     out  playing effect: 0 none, 1 eat, 2 hit, 3 die
// Macro SFX_VOLUME_ENV_EN: per-frame decaying volume envelope (floor 4);
// otherwise volume is 15 while busy.
module sfx_sequencer #(
   parameter int PRESCALE    = 64,
   parameter int NOTE_FRAMES = 6,
   parameter int HP_W        = 10
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_end,
   input  logic       eat_sound,
   input  logic       hit_sound,
   input  logic       die_sound,
   output logic       audio_out,
   output logic [3:0] volume,
   output logic       busy,
   output logic [1:0] sfx_id
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam int FW = NOTE_FRAMES > 1 ? $clog2(NOTE_FRAMES) : 1;
   // indexed by {sfx_id, note}; the sfx_id=0 row is never played but kept nonzero
   localparam logic [15:0][9:0] HP_ROM = {
      10'h200, 10'h1A0, 10'h160, 10'h120,
      10'h1C0, 10'h180, 10'h140, 10'h100,
      10'h050, 10'h060, 10'h080, 10'h0A0,
      10'h001, 10'h001, 10'h001, 10'h001};
   typedef enum logic {IDLE, PLAY} state_t;
   state_t          state, state_nx;
   logic [1:0]      id_nx, note, note_nx, trig_id;
   logic [FW-1:0]   frame_cnt, frame_nx;
   logic [PW-1:0]   pre_cnt, pre_nx;
   logic [HP_W-1:0] tone_cnt, tone_nx, hp;
   logic            aud_nx, accept, tick, last_frame, half_done;
   assign trig_id    = die_sound ? 2'd3 : hit_sound ? 2'd2 : eat_sound ? 2'd1 : 2'd0;
   // sfx_id is 0 in IDLE, so any trigger is accepted there
   assign accept     = trig_id != 2'd0 && trig_id >= sfx_id;
   assign hp         = HP_W'(HP_ROM[{sfx_id, note}]);
   assign tick       = pre_cnt == PW'(PRESCALE - 1);
   assign half_done  = tone_cnt == hp - HP_W'(1);
   assign last_frame = state == PLAY && frame_end && frame_cnt == FW'(NOTE_FRAMES - 1);
   assign busy       = state == PLAY;
   always_comb begin
      state_nx = state;
      id_nx    = sfx_id;
      note_nx  = note;
      frame_nx = frame_cnt;
      pre_nx   = pre_cnt;
      tone_nx  = tone_cnt;
      aud_nx   = audio_out;
      if (accept) begin
         state_nx = PLAY;
         id_nx    = trig_id;
         note_nx  = 2'd0;
         frame_nx = '0;
         pre_nx   = '0;
         tone_nx  = '0;
         aud_nx   = 1'b1;
      end else if (last_frame) begin
         state_nx = note == 2'd3 ? IDLE : PLAY;
         id_nx    = note == 2'd3 ? 2'd0 : sfx_id;
         note_nx  = note == 2'd3 ? 2'd0 : note + 2'd1;
         frame_nx = '0;
         pre_nx   = '0;
         tone_nx  = '0;
         aud_nx   = note != 2'd3;
      end else if (state == PLAY) begin
         frame_nx = frame_end ? frame_cnt + FW'(1) : frame_cnt;
         pre_nx   = tick ? '0 : pre_cnt + PW'(1);
         tone_nx  = !tick ? tone_cnt : half_done ? '0 : tone_cnt + HP_W'(1);
         aud_nx   = tick && half_done ? ~audio_out : audio_out;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         sfx_id    <= 2'd0;
         note      <= 2'd0;
         frame_cnt <= '0;
         pre_cnt   <= '0;
         tone_cnt  <= '0;
         audio_out <= 1'b0;
      end else begin
         state     <= state_nx;
         sfx_id    <= id_nx;
         note      <= note_nx;
         frame_cnt <= frame_nx;
         pre_cnt   <= pre_nx;
         tone_cnt  <= tone_nx;
         audio_out <= aud_nx;
      end
   end
`ifdef SFX_VOLUME_ENV_EN
   logic [3:0] vol_nx;
   always_comb
      vol_nx = accept ? 4'd15 :
               !(state == PLAY && frame_end) ? volume :
               last_frame && note == 2'd3 ? 4'd0 :
               volume > 4'd4 ? volume - 4'd1 : 4'd4;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) volume <= 4'd0;
      else volume <= vol_nx;
   end
`else
   assign volume = busy ? 4'd15 : 4'd0;
`endif
endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: scoreboard bench for sfx_sequencer with PRESCALE=2, NOTE_FRAMES=2
module tb_sfx_sequencer;
   logic clk = 1'b0, reset_n = 1'b1, frame_end = 1'b0;
   logic eat_sound = 1'b0, hit_sound = 1'b0, die_sound = 1'b0;
   logic audio_out, busy;
   logic [3:0] volume;
   logic [1:0] sfx_id;
   int checks = 0, errors = 0;
   typedef struct packed {logic b; logic [1:0] id; logic ca; logic a; logic [3:0] v;} exp_t;
   exp_t exp_q[$];
   int ivl_q[$];
   exp_t e;
   int k, iv;

   sfx_sequencer #(.PRESCALE(2), .NOTE_FRAMES(2)) dut (
      .clk(clk), .reset_n(reset_n), .frame_end(frame_end),
      .eat_sound(eat_sound), .hit_sound(hit_sound), .die_sound(die_sound),
      .audio_out(audio_out), .volume(volume), .busy(busy), .sfx_id(sfx_id));

   always #5 clk = ~clk;

   // expected volume: fe = frame_ends seen since the effect started
   function automatic logic [3:0] vexp(logic b, int fe);
`ifdef SFX_VOLUME_ENV_EN
      return !b ? 4'd0 : (15 - fe > 4) ? 4'(15 - fe) : 4'd4;
`else
      return b ? 4'd15 : 4'd0;
`endif
   endfunction

   task automatic push(logic b, logic [1:0] id, logic ca, logic a, int fe);
      exp_q.push_back({b, id, ca, a, vexp(b, fe)});
   endtask

   task automatic trig(logic ea, logic hi, logic di, logic fr);
      eat_sound = ea; hit_sound = hi; die_sound = di; frame_end = fr;
      @(negedge clk);
      eat_sound = 0; hit_sound = 0; die_sound = 0; frame_end = 0;
   endtask

   task automatic measure(output int n);
      logic p;
      p = audio_out;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (audio_out === p && n < 2000);
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      push(0, 0, 1, 0, 0);
      #1 e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, audio_out, volume} !== {e.b, e.id, e.a, e.v}) begin errors++;
         $display("FAIL reset_init: got b/id/a/v=%b/%0d/%b/%0d want %b/%0d/%b/%0d", busy, sfx_id, audio_out, volume, e.b, e.id, e.a, e.v); end
      @(negedge clk) reset_n = 1'b1;
      @(negedge clk);
      trig(1, 0, 0, 0);
      repeat (10) @(negedge clk);
      #2 reset_n = 1'b0;
      push(0, 0, 1, 0, 0);
      #1 e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, audio_out, volume} !== {e.b, e.id, e.a, e.v}) begin errors++;
         $display("FAIL reset_midplay: got b/id/a/v=%b/%0d/%b/%0d want %b/%0d/%b/%0d", busy, sfx_id, audio_out, volume, e.b, e.id, e.a, e.v); end
      @(negedge clk) reset_n = 1'b1;
      repeat (20) @(negedge clk);
      trig(0, 0, 0, 1);
      repeat (5) @(negedge clk);
      push(0, 0, 1, 0, 0);
      e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, audio_out, volume} !== {e.b, e.id, e.a, e.v}) begin errors++;
         $display("FAIL reset_release: got b/id/a/v=%b/%0d/%b/%0d want %b/%0d/%b/%0d", busy, sfx_id, audio_out, volume, e.b, e.id, e.a, e.v); end
   endtask

   task automatic test_eat();
      trig(1, 0, 0, 0);
      push(1, 1, 1, 1, 0);
      e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, audio_out, volume} !== {e.b, e.id, e.a, e.v}) begin errors++;
         $display("FAIL eat_start: got b/id/a/v=%b/%0d/%b/%0d want %b/%0d/%b/%0d", busy, sfx_id, audio_out, volume, e.b, e.id, e.a, e.v); end
      for (int t = 0; t < 2; t++) begin
         ivl_q.push_back(320);
         measure(k);
         iv = ivl_q.pop_front(); checks++;
         if (k !== iv) begin errors++; $display("FAIL eat_note0_period[%0d]: got %0d clk want %0d", t, k, iv); end
      end
      for (int i = 1; i <= 8; i++) begin
         trig(0, 0, 0, 1);
         push(i < 8, i < 8 ? 2'd1 : 2'd0, (i % 2 == 0), i < 8, i);
         e = exp_q.pop_front(); checks++;
         if ({busy, sfx_id, audio_out | ~e.ca, volume} !== {e.b, e.id, e.a | ~e.ca, e.v}) begin errors++;
            $display("FAIL eat_frame%0d: got b/id/a/v=%b/%0d/%b/%0d want %b/%0d/%b/%0d", i, busy, sfx_id, audio_out, volume, e.b, e.id, e.a, e.v); end
         if (i == 2) begin
            ivl_q.push_back(256);
            measure(k);
            iv = ivl_q.pop_front(); checks++;
            if (k !== iv) begin errors++; $display("FAIL eat_note1_period: got %0d clk want %0d", k, iv); end
         end
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic test_simultaneous();
      trig(1, 0, 1, 0);
      push(1, 3, 1, 1, 0);
      e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, audio_out, volume} !== {e.b, e.id, e.a, e.v}) begin errors++;
         $display("FAIL simul_start: got b/id/a/v=%b/%0d/%b/%0d want %b/%0d/%b/%0d", busy, sfx_id, audio_out, volume, e.b, e.id, e.a, e.v); end
      ivl_q.push_back(576);
      measure(k);
      iv = ivl_q.pop_front(); checks++;
      if (k !== iv) begin errors++; $display("FAIL die_note0_period: got %0d clk want %0d", k, iv); end
      repeat (8) begin trig(0, 0, 0, 1); repeat (2) @(negedge clk); end
      push(0, 0, 1, 0, 0);
      e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, audio_out, volume} !== {e.b, e.id, e.a, e.v}) begin errors++;
         $display("FAIL simul_end: got b/id/a/v=%b/%0d/%b/%0d want %b/%0d/%b/%0d", busy, sfx_id, audio_out, volume, e.b, e.id, e.a, e.v); end
   endtask

   task automatic test_preempt();
      trig(0, 1, 0, 0);
      trig(0, 0, 0, 1);
      repeat (2) @(negedge clk);
      trig(1, 0, 0, 0);
      push(1, 2, 0, 0, 1);
      e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, volume} !== {e.b, e.id, e.v}) begin errors++;
         $display("FAIL eat_dropped: got b/id/v=%b/%0d/%0d want %b/%0d/%0d", busy, sfx_id, volume, e.b, e.id, e.v); end
      trig(0, 0, 0, 1);
      repeat (7) @(negedge clk);
      trig(0, 0, 1, 0);
      push(1, 3, 1, 1, 0);
      e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, audio_out, volume} !== {e.b, e.id, e.a, e.v}) begin errors++;
         $display("FAIL die_preempt: got b/id/a/v=%b/%0d/%b/%0d want %b/%0d/%b/%0d", busy, sfx_id, audio_out, volume, e.b, e.id, e.a, e.v); end
      ivl_q.push_back(576);
      measure(k);
      iv = ivl_q.pop_front(); checks++;
      if (k !== iv) begin errors++; $display("FAIL preempt_note0_period: got %0d clk want %0d", k, iv); end
      repeat (8) begin trig(0, 0, 0, 1); repeat (2) @(negedge clk); end
   endtask

   task automatic test_back_to_back();
      trig(0, 1, 0, 0);
      repeat (7) begin trig(0, 0, 0, 1); repeat (2) @(negedge clk); end
      trig(0, 1, 0, 1);
      push(1, 2, 1, 1, 0);
      e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, audio_out, volume} !== {e.b, e.id, e.a, e.v}) begin errors++;
         $display("FAIL restart_at_end: got b/id/a/v=%b/%0d/%b/%0d want %b/%0d/%b/%0d", busy, sfx_id, audio_out, volume, e.b, e.id, e.a, e.v); end
      ivl_q.push_back(512);
      measure(k);
      iv = ivl_q.pop_front(); checks++;
      if (k !== iv) begin errors++; $display("FAIL restart_note0_period: got %0d clk want %0d", k, iv); end
      repeat (7) begin trig(0, 0, 0, 1); repeat (2) @(negedge clk); end
      push(1, 2, 0, 0, 7);
      e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, volume} !== {e.b, e.id, e.v}) begin errors++;
         $display("FAIL restart_full_length: got b/id/v=%b/%0d/%0d want %b/%0d/%0d", busy, sfx_id, volume, e.b, e.id, e.v); end
      trig(0, 0, 0, 1);
      push(0, 0, 1, 0, 0);
      e = exp_q.pop_front(); checks++;
      if ({busy, sfx_id, audio_out, volume} !== {e.b, e.id, e.a, e.v}) begin errors++;
         $display("FAIL restart_end: got b/id/a/v=%b/%0d/%b/%0d want %b/%0d/%b/%0d", busy, sfx_id, audio_out, volume, e.b, e.id, e.a, e.v); end
   endtask

   task automatic test_volume();
      trig(0, 0, 1, 0);
      for (int i = 1; i <= 14; i++) begin
         trig(0, 0, 0, 1);
         push(i < 8, i < 8 ? 2'd3 : 2'd0, 0, 0, i);
         e = exp_q.pop_front(); checks++;
         if ({busy, sfx_id, volume} !== {e.b, e.id, e.v}) begin errors++;
            $display("FAIL volume_frame%0d: got b/id/v=%b/%0d/%0d want %b/%0d/%0d", i, busy, sfx_id, volume, e.b, e.id, e.v); end
         @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_eat();
      test_simultaneous();
      test_preempt();
      test_back_to_back();
      test_volume();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
